// File: rtl/mips_main_control_if.sv
// Control bus between the multicycle MIPS main controller and its datapath.
// The master side is the controller; the slave side is the datapath.
interface mips_main_control_if #(
    parameter int unsigned OPW = 6
);
    logic [OPW-1:0] opcode;
    logic           mem_ready;
    logic           pc_write;
    logic           pc_write_cond;
    logic           i_or_d;
    logic           mem_read;
    logic           mem_write;
    logic           ir_write;
    logic           mem_to_reg;
    logic           reg_write;
    logic           reg_dst;
    logic           alu_src_a;
    logic [1:0]     alu_src_b;
    logic [1:0]     alu_op;
    logic [1:0]     pc_source;
    logic [3:0]     state;
    logic           retire;
    logic           halted;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
               pc_source, state, retire, halted
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
               pc_source, state, retire, halted
    );
endinterface

// File: rtl/mips_main_control.sv
// Main control FSM for the multicycle MIPS core: sequences fetch, decode,
// execute, memory and writeback, stalling on the shared-memory ready handshake.
module mips_main_control #(
    parameter int unsigned OPW = 6
) (
    input logic                 clock,
    input logic                 reset_n,
    mips_main_control_if.master ctl
);
    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9,
        ST_ADDIEX = 4'd10,
        ST_ADDIWB = 4'd11,
        ST_JUMP   = 4'd12,
        ST_TRAP   = 4'd15
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       retire;
        logic       halted;
    } ctrl_t;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

    state_t state;
    state_t nxt;
    ctrl_t  ctrl_q;
    logic   fetch_done;
    logic   store_done;

    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            ST_DECODE: c.alu_src_b = 2'b11;
            ST_MEMADR, ST_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            ST_MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            ST_MEMWR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            ST_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.retire     = 1'b1;
            end
            ST_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            ST_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.retire    = 1'b1;
            end
            ST_ADDIWB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.retire        = 1'b1;
            end
            ST_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
                c.retire    = 1'b1;
            end
            ST_TRAP: c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt = state;
        case (state)
            ST_RST:   nxt = ST_FETCH;
            ST_FETCH: if (ctl.mem_ready) nxt = ST_DECODE;
            ST_DECODE: begin
                if (ctl.opcode == OP_RTYPE)
                    nxt = ST_EXEC;
                else if (ctl.opcode == OP_LW || ctl.opcode == OP_SW)
                    nxt = ST_MEMADR;
                else if (ctl.opcode == OP_BEQ)
                    nxt = ST_BRANCH;
                else if (ctl.opcode == OP_ADDI)
                    nxt = ST_ADDIEX;
                else if (ctl.opcode == OP_J)
                    nxt = ST_JUMP;
                else
                    nxt = ST_TRAP;
            end
            ST_MEMADR: begin
                if (ctl.opcode == OP_LW)
                    nxt = ST_MEMRD;
                else if (ctl.opcode == OP_SW)
                    nxt = ST_MEMWR;
                else
                    nxt = ST_TRAP;
            end
            ST_MEMRD:  if (ctl.mem_ready) nxt = ST_MEMWB;
            ST_MEMWR:  if (ctl.mem_ready) nxt = ST_FETCH;
            ST_EXEC:   nxt = ST_ALUWB;
            ST_ADDIEX: nxt = ST_ADDIWB;
            ST_MEMWB, ST_ALUWB, ST_ADDIWB, ST_BRANCH, ST_JUMP: nxt = ST_FETCH;
            ST_TRAP:   nxt = ST_TRAP;
            default:   nxt = ST_TRAP;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with
    // the state register and clear together with it on async reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_RST;
            ctrl_q <= '0;
        end else begin
            state  <= nxt;
            ctrl_q <= ctrl_for(nxt);
        end
    end

    assign fetch_done = (state == ST_FETCH) && ctl.mem_ready;
    assign store_done = (state == ST_MEMWR) && ctl.mem_ready;

    assign ctl.pc_write      = ctrl_q.pc_write | fetch_done;
    assign ctl.ir_write      = fetch_done;
    assign ctl.pc_write_cond = ctrl_q.pc_write_cond;
    assign ctl.i_or_d        = ctrl_q.i_or_d;
    assign ctl.mem_read      = ctrl_q.mem_read;
    assign ctl.mem_write     = ctrl_q.mem_write;
    assign ctl.mem_to_reg    = ctrl_q.mem_to_reg;
    assign ctl.reg_write     = ctrl_q.reg_write;
    assign ctl.reg_dst       = ctrl_q.reg_dst;
    assign ctl.alu_src_a     = ctrl_q.alu_src_a;
    assign ctl.alu_src_b     = ctrl_q.alu_src_b;
    assign ctl.alu_op        = ctrl_q.alu_op;
    assign ctl.pc_source     = ctrl_q.pc_source;
    assign ctl.state         = state;
    assign ctl.retire        = ctrl_q.retire | store_done;
    assign ctl.halted        = ctrl_q.halted;
endmodule

// File: tb/tb_mips_main_control.sv
// Directed-vector bench for mips_main_control: walks each instruction class
// through the FSM and compares every output against the state table.
module tb_mips_main_control;
    logic clock;
    logic reset_n;
    int unsigned nchk;
    int unsigned nerr;
    int unsigned nretire;

    mips_main_control_if #(.OPW(6)) bus ();

    mips_main_control #(.OPW(6)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .ctl     (bus.master)
    );

    logic [21:0] obs;
    assign obs = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                  bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_write,
                  bus.reg_dst, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                  bus.pc_source, bus.state, bus.retire, bus.halted};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [21:0] exp_out(input logic [3:0] st, input logic mr);
        logic pw, pwc, iod, mrd, mwr, irw, m2r, rw, rd, asa, rt, hl;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, iod, mrd, mwr, irw, m2r, rw, rd, asa, rt, hl} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            4'd1:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pw = mr; end
            4'd2:  asb = 2'b11;
            4'd3:  begin asa = 1'b1; asb = 2'b10; end
            4'd4:  begin mrd = 1'b1; iod = 1'b1; end
            4'd5:  begin rw = 1'b1; m2r = 1'b1; rt = 1'b1; end
            4'd6:  begin mwr = 1'b1; iod = 1'b1; rt = mr; end
            4'd7:  begin asa = 1'b1; aop = 2'b10; end
            4'd8:  begin rw = 1'b1; rd = 1'b1; rt = 1'b1; end
            4'd9:  begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; rt = 1'b1; end
            4'd10: begin asa = 1'b1; asb = 2'b10; end
            4'd11: begin rw = 1'b1; rt = 1'b1; end
            4'd12: begin pw = 1'b1; psrc = 2'b10; rt = 1'b1; end
            4'd15: hl = 1'b1;
            default: ;
        endcase
        return {pw, pwc, iod, mrd, mwr, irw, m2r, rw, rd, asa, asb, aop, psrc, st, rt, hl};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle, present mem_ready for it, then compare all outputs.
    task automatic tick(input logic mr, input logic [3:0] st, input string tag);
        @(posedge clock);
        #1 bus.mem_ready = mr;
        #1;
        check_eq({tag, ".state"}, 32'(bus.state), 32'(st));
        check_eq({tag, ".outs"}, 32'(obs), 32'(exp_out(st, mr)));
        if (bus.retire) nretire++;
    endtask

    initial begin
        nchk = 0; nerr = 0; nretire = 0;
        reset_n       = 1'b1;
        bus.mem_ready = 1'b0;
        bus.opcode    = 6'b000000;
        #1 reset_n = 1'b0;
        #2;
        check_eq("reset.async", 32'(obs), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #2 reset_n = 1'b1;
        #1;
        check_eq("reset.rst_state", 32'(obs), 32'd0);

        // lw, memory always ready
        bus.opcode = 6'b100011;
        tick(1'b1, 4'd1, "lw.fetch");
        tick(1'b1, 4'd2, "lw.decode");
        tick(1'b1, 4'd3, "lw.memadr");
        tick(1'b1, 4'd4, "lw.memrd");
        tick(1'b1, 4'd5, "lw.memwb");

        // sw with three stall cycles in MEMWR
        bus.opcode = 6'b101011;
        tick(1'b1, 4'd1, "sw.fetch");
        tick(1'b1, 4'd2, "sw.decode");
        tick(1'b1, 4'd3, "sw.memadr");
        tick(1'b0, 4'd6, "sw.wait0");
        tick(1'b0, 4'd6, "sw.wait1");
        tick(1'b0, 4'd6, "sw.wait2");
        tick(1'b1, 4'd6, "sw.done");
        check_eq("sw.retires", nretire, 32'd2);

        // R-type, addi, beq, j back to back
        nretire = 0;
        bus.opcode = 6'b000000;
        tick(1'b1, 4'd1, "r.fetch");
        tick(1'b1, 4'd2, "r.decode");
        tick(1'b1, 4'd7, "r.exec");
        tick(1'b1, 4'd8, "r.aluwb");
        bus.opcode = 6'b001000;
        tick(1'b1, 4'd1, "addi.fetch");
        tick(1'b1, 4'd2, "addi.decode");
        tick(1'b1, 4'd10, "addi.ex");
        tick(1'b1, 4'd11, "addi.wb");
        bus.opcode = 6'b000100;
        tick(1'b1, 4'd1, "beq.fetch");
        tick(1'b1, 4'd2, "beq.decode");
        tick(1'b1, 4'd9, "beq.branch");
        bus.opcode = 6'b000010;
        tick(1'b1, 4'd1, "j.fetch");
        tick(1'b1, 4'd2, "j.decode");
        tick(1'b1, 4'd12, "j.jump");
        check_eq("seq.retires", nretire, 32'd4);

        // fetch stall, then illegal opcode traps
        bus.opcode = 6'b111111;
        tick(1'b0, 4'd1, "ill.fetch_wait0");
        tick(1'b0, 4'd1, "ill.fetch_wait1");
        tick(1'b1, 4'd1, "ill.fetch");
        tick(1'b1, 4'd2, "ill.decode");
        for (int i = 0; i < 20; i++)
            tick(1'($urandom_range(0, 1)), 4'd15, "ill.trap");
        #1 reset_n = 1'b0;
        #1;
        check_eq("trap.reset_async", 32'(obs), 32'd0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        #1;
        check_eq("trap.rst_state", 32'(bus.state), 32'd0);

        // async reset in the middle of ALUWB
        bus.opcode = 6'b000000;
        tick(1'b1, 4'd1, "r2.fetch");
        tick(1'b1, 4'd2, "r2.decode");
        tick(1'b1, 4'd7, "r2.exec");
        tick(1'b1, 4'd8, "r2.aluwb");
        #1 reset_n = 1'b0;
        #1;
        check_eq("aluwb.reset_reg_write", 32'(bus.reg_write), 32'd0);
        check_eq("aluwb.reset_state", 32'(bus.state), 32'd0);
        check_eq("aluwb.reset_outs", 32'(obs), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/mips_main_control.md
# mips_main_control

Moore-style main control FSM for the multicycle MIPS core. It sits beside the shared-memory datapath inside `MIPS` and sequences it for each instruction: fetch, decode, execute, memory and writeback. It drives every mux select, write enable and ALU-op code, and stalls on a memory-ready handshake. Illegal opcodes halt the core.

## Interface
- `OPW`, 6, opcode width (instr[31:26])
- `clock`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `opcode`  in  6  IR[31:26], stable from DECODE onward
- `mem_ready`  in  1  shared memory completed the current access this cycle
- `pc_write`, `pc_write_cond`, `i_or_d`, `mem_read`, `mem_write`, `ir_write`, `mem_to_reg`, `reg_write`, `reg_dst`, `alu_src_a`  out  1 each  datapath controls
- `alu_src_b`  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- `alu_op`  out  2  00 = add, 01 = sub, 10 = funct-decoded
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `state`  out  4  current state encoding (debug)
- `retire`  out  1  one-cycle pulse in the last cycle of each instruction
- `halted`  out  1  high while in TRAP

## Operation
- State encodings: RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12, TRAP=15. Codes 13 and 14 are unreachable and go to TRAP.
- Transitions:
  - RST -> FETCH.
  - FETCH holds while `mem_ready`=0, then -> DECODE.
  - DECODE on `opcode`: 000000 -> EXEC; 100011 (lw) or 101011 (sw) -> MEMADR; 000100 (beq) -> BRANCH; 001000 (addi) -> ADDIEX; 000010 (j) -> JUMP; any other opcode -> TRAP.
  - MEMADR -> MEMRD for lw, MEMWR for sw.
  - MEMRD holds until `mem_ready`, then -> MEMWB.
  - MEMWR holds until `mem_ready`, then -> FETCH.
  - EXEC -> ALUWB; ADDIEX -> ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
  - TRAP holds until reset.
- Outputs per state. Any output not listed is 0.
  - RST: all outputs 0.
  - FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00. `ir_write` and `pc_write` equal `mem_ready`; this is the only Mealy term besides MEMWR/MEMRD exit.
  - DECODE: alu_src_b=11, alu_op=00.
  - MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEMRD: mem_read=1, i_or_d=1.
  - MEMWR: mem_write=1, i_or_d=1, held for the whole wait.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
  - ALUWB: reg_write=1, reg_dst=1.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0.
  - BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01.
  - JUMP: pc_write=1, pc_source=10.
  - TRAP: all 0, halted=1.
- `retire`=1 in MEMWB, ALUWB, ADDIWB, BRANCH and JUMP, and in MEMWR when `mem_ready`=1.

## Timing
- Reset: `reset_n` low forces state=RST immediately, without waiting for a clock edge. All outputs are 0 in RST, including halted and retire.
- First FETCH occurs on the first rising edge after `reset_n` rises. Reset asserted mid-instruction aborts it; no write enable may be seen after the reset edge.
- Latency with `mem_ready` tied high: R-type 4 cycles, lw 5, sw 4, beq 3, addi 4, j 3.
- Each cycle `mem_ready` is low in FETCH, MEMRD or MEMWR adds exactly one cycle. Controls stay constant during the wait.
- `opcode` is sampled only in DECODE and in MEMADR.
- The BRANCH taken/not-taken decision is made by the datapath (`pc_write_cond` AND zero). Cycle count is the same either way.
- No write enable (`pc_write`, `ir_write`, `reg_write`, `mem_write`) may be asserted in two consecutive states unless the table above says so.

## Test plan
- Reset then lw (opcode 100011), `mem_ready`=1 -> states 0,1,2,3,4,5,1. `retire` high only in MEMWB. `reg_write`=`mem_to_reg`=1 in MEMWB.
- sw with `mem_ready` low for 3 cycles in MEMWR -> state 6 held 4 cycles with `mem_write`=1 and `i_or_d`=1. `retire` high only in the final cycle. Next state is 1.
- FETCH with `mem_ready` low for 2 cycles -> `ir_write`=`pc_write`=0 for 2 cycles, then 1 for one cycle. DECODE follows.
- Sequence R-type, addi, beq, j -> total 4+4+3+3 = 14 cycles and exactly 4 `retire` pulses. In the beq state, `alu_op`=01 and `pc_source`=01; in the j state, `pc_source`=10 and `pc_write`=1.
- Opcode 111111 in DECODE -> state 15 and `halted`=1, with all controls 0 for 20 cycles. `reset_n` pulse low -> state 0 immediately.
- Drive `reset_n` low in the middle of ALUWB (async, between edges) -> `reg_write` drops to 0 within the same cycle, and state reads 0 before the next edge.
